// File: rtl/inv_vec_apply_pkg.sv
// Shared constants, state encoding and coefficient record for the 2x2 inverse-apply block.
// All data is signed Q2.14; the accumulator is Q5.28.
package inv_vec_apply_pkg;

  localparam int IN_I   = 2;
  localparam int IN_F   = 14;
  localparam int DATA_W = IN_I + IN_F;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 33;

  localparam int Q_MAX      = 32767;
  localparam int Q_MIN      = -32768;
  localparam int ROUND_HALF = 8192;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_OUT  = 3'd5
  } state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic signed [DATA_W-1:0] c;
    logic signed [DATA_W-1:0] d;
    logic                     err;
  } coef_t;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/inv_vec_apply_q_round_sat.sv
// Converts a Q5.28 accumulator to Q2.14: round half-up, arithmetic shift, saturate.
module q_round_sat
  import inv_vec_apply_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] q_o
);

  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(ROUND_HALF);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(Q_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(Q_MIN);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    rounded = acc_i + RND;
    shifted = rounded >>> IN_F;
    if (shifted > SAT_HI) begin
      q_o = SAT_HI[DATA_W-1:0];
    end else if (shifted < SAT_LO) begin
      q_o = SAT_LO[DATA_W-1:0];
    end else begin
      q_o = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/inv_vec_apply.sv
// Applies a latched 2x2 inverse to a stream of vectors with one shared multiplier.
//   state | meaning
//   IDLE  | wait for vector; commit pending coefficients
//   M0    | acc = a*x0
//   M1    | y0  = rs(acc + b*x1)
//   M2    | acc = c*x0
//   M3    | y1  = rs(acc + d*x1), raise out_valid
//   OUT   | hold result until out_ready
module inv_vec_apply
  import inv_vec_apply_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inv_load,
  input  logic signed [DATA_W-1:0] a_inv,
  input  logic signed [DATA_W-1:0] b_inv,
  input  logic signed [DATA_W-1:0] c_inv,
  input  logic signed [DATA_W-1:0] d_inv,
  input  logic                     inv_error,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] x1,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y0,
  output logic signed [DATA_W-1:0] y1,
  output logic                     out_err
);

  state_e state_q, state_d;
  coef_t  shadow_q, shadow_d;
  coef_t  active_q, active_d;
  coef_t  snap_q, snap_d;
  logic   coef_valid_q, coef_valid_d;
  logic   pending_q, pending_d;

  logic signed [DATA_W-1:0] x0_q, x0_d;
  logic signed [DATA_W-1:0] x1_q, x1_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] y0_q, y0_d;
  logic signed [DATA_W-1:0] y1_q, y1_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_err_q, out_err_d;

  logic signed [DATA_W-1:0] mul_a;
  logic signed [DATA_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  rs_in;
  logic signed [DATA_W-1:0] rs_out;
  logic                     accept;

  assign in_ready  = (state_q == ST_IDLE) && coef_valid_q && !pending_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign y0        = y0_q;
  assign y1        = y1_q;

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_a = snap_q.a;
    mul_b = x0_q;
    case (state_q)
      ST_M1:   begin mul_a = snap_q.b; mul_b = x1_q; end
      ST_M2:   begin mul_a = snap_q.c; mul_b = x0_q; end
      ST_M3:   begin mul_a = snap_q.d; mul_b = x1_q; end
      default: begin mul_a = snap_q.a; mul_b = x0_q; end
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = sext_prod(prod);
  assign rs_in    = acc_q + prod_ext;

  q_round_sat u_rs (
    .acc_i (rs_in),
    .q_o   (rs_out)
  );

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    coef_valid_d = coef_valid_q;
    pending_d    = pending_q;

    // Commit uses the previously captured shadow; a same-cycle load stays pending.
    if ((state_q == ST_IDLE) && pending_q) begin
      active_d     = shadow_q;
      coef_valid_d = 1'b1;
      pending_d    = 1'b0;
    end
    if (inv_load) begin
      shadow_d  = '{a: a_inv, b: b_inv, c: c_inv, d: d_inv, err: inv_error};
      pending_d = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    acc_d       = acc_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x0_d    = x0;
          x1_d    = x1;
          snap_d  = active_q;
          state_d = ST_M0;
        end
      end
      ST_M0: begin
        acc_d   = prod_ext;
        state_d = ST_M1;
      end
      ST_M1: begin
        y0_d    = snap_q.err ? '0 : rs_out;
        state_d = ST_M2;
      end
      ST_M2: begin
        acc_d   = prod_ext;
        state_d = ST_M3;
      end
      ST_M3: begin
        y1_d        = snap_q.err ? '0 : rs_out;
        out_valid_d = 1'b1;
        out_err_d   = snap_q.err;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      active_q     <= '0;
      snap_q       <= '0;
      coef_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      x0_q         <= '0;
      x1_q         <= '0;
      acc_q        <= '0;
      y0_q         <= '0;
      y1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      snap_q       <= snap_d;
      coef_valid_q <= coef_valid_d;
      pending_q    <= pending_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      acc_q        <= acc_d;
      y0_q         <= y0_d;
      y1_q         <= y1_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule

// File: tb/tb_inv_vec_apply.sv
// Scoreboard bench for inv_vec_apply: stimulus queues expected results, a monitor checks them.
module tb_inv_vec_apply;

  logic        clk = 1'b0;
  logic        reset;
  logic        inv_load;
  logic [15:0] a_inv, b_inv, c_inv, d_inv;
  logic        inv_error;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x0, x1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y0, y1;
  logic        out_err;

  typedef struct packed {
    logic [15:0] y0;
    logic [15:0] y1;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests  = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inv_vec_apply dut (
    .clk       (clk),
    .reset     (reset),
    .inv_load  (inv_load),
    .a_inv     (a_inv),
    .b_inv     (b_inv),
    .c_inv     (c_inv),
    .d_inv     (d_inv),
    .inv_error (inv_error),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y0        (y0),
    .y1        (y1),
    .out_err   (out_err)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int a, input int b, input int c, input int d, input bit err);
    a_inv     = 16'(a);
    b_inv     = 16'(b);
    c_inv     = 16'(c);
    d_inv     = 16'(d);
    inv_error = err;
    inv_load  = 1'b1;
    @(posedge clk); #1;
    inv_load  = 1'b0;
  endtask

  task automatic send(input int vx0, input int vx1, input int ey0, input int ey1,
                      input bit eerr, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", int'(in_ready), 1);
    if (in_ready) begin
      x0       = 16'(vx0);
      x1       = 16'(vx1);
      in_valid = 1'b1;
      if (push) exp_q.push_back('{y0: 16'(ey0), y1: 16'(ey1), err: eerr});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input string name, input int exp_cycles);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n, exp_cycles);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("y0",      int'($signed(y0)),      int'($signed(mon_e.y0)));
        check("y1",      int'($signed(y1)),      int'($signed(mon_e.y1)));
        check("out_err", int'(out_err),          int'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inv_load = 1'b0; inv_error = 1'b0;
    a_inv = '0; b_inv = '0; c_inv = '0; d_inv = '0;
    in_valid = 1'b0; x0 = '0; x1 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready",  int'(in_ready),  0);
    check("rst_y0",        int'($signed(y0)), 0);
    check("rst_y1",        int'($signed(y1)), 0);
    check("rst_out_err",   int'(out_err),   0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("nocoef_in_ready", int'(in_ready), 0);

    // identity
    load(16384, 0, 0, 16384, 0);
    send(8192, -4096, 8192, -4096, 0, 1);
    wait_out("ident_latency", 4);

    // rounding half-up at the boundary, both signs
    load(1, 0, 0, 0, 0);
    send(8192, 0, 1, 0, 0, 1);    wait_out("rnd_lat_a", 4);
    send(8191, 0, 0, 0, 0, 1);    wait_out("rnd_lat_b", 4);
    send(-8192, 0, 0, 0, 0, 1);   wait_out("rnd_lat_c", 4);
    send(-8193, 0, -1, 0, 0, 1);  wait_out("rnd_lat_d", 4);

    // saturation
    load(32767, 32767, 0, 0, 0);
    send(32767, 32767, 32767, 0, 0, 1);   wait_out("sat_hi_lat", 4);
    load(-32768, -32768, 0, 0, 0);
    send(32767, 32767, -32768, 0, 0, 1);  wait_out("sat_lo_lat", 4);

    // singular inverse
    load(16384, 0, 0, 16384, 1);
    send(8192, -4096, 0, 0, 1, 1);
    wait_out("err_latency", 4);

    // backpressure
    load(16384, 0, 0, 16384, 0);
    out_ready = 1'b0;
    send(4096, 12288, 4096, 12288, 0, 1);
    wait_out("bp_latency", 4);
    for (int i = 0; i < 10; i++) begin
      check("bp_y0",        int'($signed(y0)), 4096);
      check("bp_y1",        int'($signed(y1)), 12288);
      check("bp_out_valid", int'(out_valid),   1);
      check("bp_in_ready",  int'(in_ready),    0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;

    // deferred load: vector computed with half matrix, load identity during M2
    load(8192, 0, 0, 8192, 0);
    send(8192, -4096, 4096, -2048, 0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    load(16384, 0, 0, 16384, 0);
    wait_out("defer_latency", 1);
    @(posedge clk); #1;
    check("commit_gap_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    check("commit_done_in_ready", int'(in_ready), 1);
    send(8192, -4096, 8192, -4096, 0, 1);
    wait_out("post_commit_latency", 4);

    // reset in M1 aborts immediately
    @(posedge clk); #1;
    send(4096, 4096, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready",  int'(in_ready),  0);
    check("midrst_y0",        int'($signed(y0)), 0);
    check("midrst_y1",        int'($signed(y1)), 0);
    check("midrst_out_err",   int'(out_err),   0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("postrst_in_ready",  int'(in_ready),  0);
    check("postrst_out_valid", int'(out_valid), 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
